audio_voice_scheduler: RTL

Sequences the audio output path: collects one sample per frame from up to NUM_VOICES synth voice generators, sums them with gain scaling and saturation, and issues exactly one write per frame into the Audio_Controller output FIFO. Voices are polled in fixed index order, each with a one-cycle ack handshake. The block sits between the voice/wave generators and Audio_Controller. It drives left_channel_audio_out, right_channel_audio_out and write_audio_out, and consumes audio_out_allowed.

---
 rtl/audio_voice_scheduler_if.sv | 29 ++
 rtl/audio_voice_scheduler.sv | 108 ++++++++++
 2 files changed

// File: rtl/audio_voice_scheduler_if.sv
// Voice-side and Audio_Controller-side signals of the voice scheduler.
// The scheduler connects through the master modport; the environment uses slave.
interface audio_voice_scheduler_if #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 32
);
   logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
   logic [NUM_VOICES-1:0]          voice_valid;
   logic [NUM_VOICES-1:0]          voice_enable;
   logic [NUM_VOICES-1:0]          voice_ack;
   logic                           audio_out_allowed;
   logic [SAMPLE_W-1:0]            left_channel_audio_out;
   logic [SAMPLE_W-1:0]            right_channel_audio_out;
   logic                           write_audio_out;
   logic [15:0]                    frame_count;
   logic [7:0]                     underrun_count;

   modport master (
      input  voice_sample, voice_valid, voice_enable, audio_out_allowed,
      output voice_ack, left_channel_audio_out, right_channel_audio_out,
             write_audio_out, frame_count, underrun_count
   );

   modport slave (
      output voice_sample, voice_valid, voice_enable, audio_out_allowed,
      input  voice_ack, left_channel_audio_out, right_channel_audio_out,
             write_audio_out, frame_count, underrun_count
   );
endinterface

// File: rtl/audio_voice_scheduler.sv
// Polls each voice once per frame, mixes with gain shift and saturation,
// and issues one write per frame into the Audio_Controller output FIFO.
module audio_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 32,
   parameter int GAIN_SHIFT = 2
) (
   input  logic CLOCK_50,
   input  logic reset,
   audio_voice_scheduler_if.master bus
);
   localparam int ACC_W = SAMPLE_W + 3;
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, SCALE, WRITE} state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [IDX_W-1:0]        idx;
   logic [SAMPLE_W-1:0]     mix;
   logic [15:0]             frames;
   logic [7:0]              underruns;

   logic [SAMPLE_W-1:0]     cur_sample;
   logic                    cur_enable;
   logic                    cur_valid;
   logic                    take;
   logic [NUM_VOICES-1:0]   ack;
   logic signed [ACC_W-1:0] shifted;
   logic                    fits;
   logic [SAMPLE_W-1:0]     sat;

   always_comb begin
      cur_sample = '0;
      cur_enable = 1'b0;
      cur_valid  = 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_sample = bus.voice_sample[i*SAMPLE_W +: SAMPLE_W];
            cur_enable = bus.voice_enable[i];
            cur_valid  = bus.voice_valid[i];
         end
      end
   end

   assign take = (state == COLLECT) && cur_enable && cur_valid;

   always_comb begin
      ack = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (take && idx == IDX_W'(i)) ack[i] = 1'b1;
      end
   end

   // The shifted sum fits when every bit above the output sign bit matches it.
   assign shifted = acc >>> GAIN_SHIFT;
   assign fits    = (&shifted[ACC_W-1:SAMPLE_W-1]) | ~(|shifted[ACC_W-1:SAMPLE_W-1]);
   assign sat     = fits ? shifted[SAMPLE_W-1:0]
                  : (shifted[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                      : {1'b0, {(SAMPLE_W-1){1'b1}}});

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         idx       <= '0;
         mix       <= '0;
         frames    <= '0;
         underruns <= '0;
      end else begin
         case (state)
            IDLE: begin
               acc <= '0;
               idx <= '0;
               if (bus.audio_out_allowed) state <= COLLECT;
            end
            COLLECT: begin
               if (take)
                  acc <= acc + $signed({{3{cur_sample[SAMPLE_W-1]}}, cur_sample});
               if (cur_enable && !cur_valid && underruns != 8'hFF)
                  underruns <= underruns + 8'd1;
               if (idx == LAST_IDX) state <= SCALE;
               else                 idx   <= idx + IDX_W'(1);
            end
            SCALE: begin
               mix   <= sat;
               state <= WRITE;
            end
            WRITE: begin
               if (bus.audio_out_allowed) begin
                  frames <= frames + 16'd1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The write strobe is gated by allowed so it can never fire into a full FIFO.
   assign bus.voice_ack               = ack;
   assign bus.write_audio_out         = (state == WRITE) && bus.audio_out_allowed;
   assign bus.left_channel_audio_out  = mix;
   assign bus.right_channel_audio_out = mix;
   assign bus.frame_count             = frames;
   assign bus.underrun_count          = underruns;
endmodule
